wb_flow_arbiter: RTL and testbench
==================================

WB_FLOW_ARBITER -- requirements
Module: wb_flow_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the data width of all data buses.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 1, the address width of all address buses.
REQ-003 The block SHALL have parameter TIMEOUT, default 1023, the number of stalled cycles before abort; legal range 1..65535.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 The clock port SHALL be clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 The reset port SHALL be rst, input, 1 bit, asynchronous active-high reset.
REQ-007 For n in {0,1}, each master port SHALL provide: mn_adr_i in ADDR_WIDTH; mn_dat_i in DATA_WIDTH; mn_dat_o out DATA_WIDTH; mn_we_i in 1; mn_stb_i in 1; mn_cyc_i in 1; mn_ack_o out 1; mn_err_o out 1 (timeout abort).
REQ-008 The shared slave port SHALL provide: s_adr_o out ADDR_WIDTH; s_dat_o out DATA_WIDTH; s_dat_i in DATA_WIDTH; s_we_o out 1; s_stb_o out 1; s_cyc_o out 1; s_ack_i in 1.
REQ-009 The block SHALL output gnt, 2 bits, one-hot current grant (bit n = master n), 2'b00 when idle.

Function
REQ-010 The FSM SHALL have states IDLE, GRANT0, GRANT1; gnt = 00/01/10 respectively, registered.
REQ-011 In IDLE with exactly one eligible mn_cyc_i high, the next state SHALL be GRANTn.
REQ-012 In IDLE with both eligible, the grant SHALL go to the master indicated by a 1-bit priority pointer prio (0 = master 0 preferred).
REQ-013 On every exit from GRANTn to IDLE, prio SHALL be set to the other master (round-robin).
REQ-014 Grant latency SHALL be exactly one cycle: request seen in IDLE in cycle t gives slave outputs active in cycle t+1.
REQ-015 In GRANTn, s_adr_o/s_dat_o/s_we_o/s_stb_o/s_cyc_o SHALL combinationally equal master n's inputs; mn_ack_o = s_ack_i.
REQ-016 In IDLE, s_stb_o, s_cyc_o, s_we_o SHALL be 0; s_adr_o and s_dat_o SHALL be 0.
REQ-017 The non-granted master's ack_o SHALL be 0; both mn_dat_o SHALL equal s_dat_i at all times.
REQ-018 GRANTn SHALL be held while mn_cyc_i is high (bus lock across multiple strobes); when mn_cyc_i is sampled low, the next state SHALL be IDLE.
REQ-019 Return through IDLE SHALL take one cycle; no direct GRANT0<->GRANT1 transition.
REQ-020 A 16-bit stall counter SHALL clear on entering GRANTn, on any s_ack_i, and whenever s_stb_o is low, and otherwise increment each cycle s_stb_o=1 and s_ack_i=0.
REQ-021 When the stall counter equals TIMEOUT with no ack that cycle, mn_err_o SHALL pulse high for exactly that cycle, mn_ack_o SHALL stay 0, and the next state SHALL be IDLE.
REQ-022 A timed-out master SHALL be set ineligible (blocked flag) until its mn_cyc_i is sampled low; the other master is unaffected.
REQ-023 mn_err_o SHALL never coincide with mn_ack_o; an ack in the timeout cycle takes precedence and no error is raised.
REQ-024 Simultaneous cyc drop and ack in the same cycle SHALL pass the ack and still return to IDLE.

Reset
REQ-025 While rst is high: state IDLE, gnt=00, prio=0, stall counter 0, both blocked flags 0, all slave outputs 0, all ack/err outputs 0.
REQ-026 Reset asserted mid-transaction SHALL drop s_cyc_o/s_stb_o immediately (asynchronously); no ack or err SHALL be produced.
REQ-027 After rst deasserts, the first arbitration SHALL occur at the first rising clk edge with rst low.

Verification
REQ-028 Single request: m1 cyc/stb, we=1, dat=8'hA5 in IDLE -> next cycle gnt=10, s_dat_o=A5, s_we_o=1; s_ack_i=1 -> m1_ack_o=1, m0_ack_o=0.
REQ-029 Contention after reset: both cyc rise same cycle -> gnt=01 first; m0 drops cyc -> IDLE one cycle -> gnt=10; repeat -> m0 wins next (round-robin).
REQ-030 Lock: m0 holds cyc over three strobes while m1 requests -> gnt stays 01 throughout; m1 granted two cycles after m0 cyc falls.
REQ-031 Timeout: TIMEOUT=4, m0 stb with s_ack_i=0 -> m0_err_o pulses once (exactly one cycle), gnt returns 00, m0 not regranted while cyc held; m1 request granted normally.
REQ-032 Ack on timeout boundary: TIMEOUT=4, s_ack_i=1 in the cycle counter reaches 4 -> m0_ack_o=1, m0_err_o=0, grant retained.
REQ-033 Async reset mid-grant: rst pulses between clk edges during GRANT1 -> s_cyc_o=0 and gnt=00 before the next edge, prio=0.

Source files
------------

// File: rtl/wb_flow_arbiter.sv
// Two-master Wishbone arbiter with bus lock, round-robin fairness and a
// stall watchdog. A master that stalls too long is aborted with an error
// and is locked out until it drops its cycle.

// Per-master bookkeeping: the lock-out flag and the ack/err gating.
module wb_flow_arbiter_port (
    input  logic clk,
    input  logic rst,
    input  logic cyc_i,
    input  logic granted_i,
    input  logic ack_i,
    input  logic timeout_i,
    output logic eligible_o,
    output logic ack_o,
    output logic err_o
);
    logic blocked_q, blocked_d;

    // Set on an abort while granted; cleared as soon as cyc is sampled low.
    always_comb begin
        blocked_d = cyc_i & (blocked_q | (granted_i & timeout_i));
    end

    // Lock-out flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) blocked_q <= 1'b0;
        else     blocked_q <= blocked_d;
    end

    assign eligible_o = cyc_i & ~blocked_q;
    assign ack_o      = granted_i & ack_i;
    // timeout_i already excludes an ack in the same cycle, so ack wins.
    assign err_o      = granted_i & timeout_i;
endmodule

module wb_flow_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 1,
    parameter int TIMEOUT    = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    // master 0
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [DATA_WIDTH-1:0] m0_dat_i,
    output logic [DATA_WIDTH-1:0] m0_dat_o,
    input  logic                  m0_we_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    // master 1
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [DATA_WIDTH-1:0] m1_dat_i,
    output logic [DATA_WIDTH-1:0] m1_dat_o,
    input  logic                  m1_we_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    // shared slave
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [DATA_WIDTH-1:0] s_dat_o,
    input  logic [DATA_WIDTH-1:0] s_dat_i,
    output logic                  s_we_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic                  s_ack_i,
    // current grant, one-hot
    output logic [1:0]            gnt
);
    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] adr;
        logic [DATA_WIDTH-1:0] dat;
        logic                  we;
        logic                  stb;
        logic                  cyc;
    } req_t;

    state_e      state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        prio_q, prio_d;
    logic [15:0] stall_q, stall_d;

    req_t [1:0]  req;
    req_t        sel;
    logic [1:0]  eligible;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic        timeout_hit;

    assign req[0] = {m0_adr_i, m0_dat_i, m0_we_i, m0_stb_i, m0_cyc_i};
    assign req[1] = {m1_adr_i, m1_dat_i, m1_we_i, m1_stb_i, m1_cyc_i};

    // Slave-side mux: the granted master's request passes straight through,
    // everything is zero while idle (and immediately on reset).
    always_comb begin
        sel = '0;
        case (state_q)
            GRANT0:  sel = req[0];
            GRANT1:  sel = req[1];
            default: sel = '0;
        endcase
    end

    assign s_adr_o = sel.adr;
    assign s_dat_o = sel.dat;
    assign s_we_o  = sel.we;
    assign s_stb_o = sel.stb;
    assign s_cyc_o = sel.cyc;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign gnt      = gnt_q;

    // The counter holds the number of stalled cycles already seen, so the
    // abort lands on the stalled cycle after TIMEOUT of them.
    assign timeout_hit = (state_q != IDLE) & sel.stb & ~s_ack_i &
                         (stall_q == TIMEOUT_C);

    for (genvar n = 0; n < 2; n++) begin : g_port
        wb_flow_arbiter_port u_port (
            .clk        (clk),
            .rst        (rst),
            .cyc_i      (req[n].cyc),
            .granted_i  (gnt_q[n]),
            .ack_i      (s_ack_i),
            .timeout_i  (timeout_hit),
            .eligible_o (eligible[n]),
            .ack_o      (ack[n]),
            .err_o      (err[n])
        );
    end

    assign m0_ack_o = ack[0];
    assign m1_ack_o = ack[1];
    assign m0_err_o = err[0];
    assign m1_err_o = err[1];

    // Arbitration, bus lock, round-robin pointer and stall watchdog.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                stall_d = '0;
                if (eligible[0] && eligible[1])
                    state_d = prio_q ? GRANT1 : GRANT0;
                else if (eligible[0])
                    state_d = GRANT0;
                else if (eligible[1])
                    state_d = GRANT1;
            end
            GRANT0, GRANT1: begin
                if (timeout_hit || !sel.cyc) begin
                    // Always pass through IDLE; hand preference to the other side.
                    state_d = IDLE;
                    prio_d  = (state_q == GRANT0);
                    stall_d = '0;
                end else if (s_ack_i || !sel.stb) begin
                    stall_d = '0;
                end else if (stall_q != 16'hFFFF) begin
                    stall_d = stall_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                stall_d = '0;
            end
        endcase
        case (state_d)
            GRANT0:  gnt_d = 2'b01;
            GRANT1:  gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase
    end

    // Arbiter state registers; reset lands in IDLE with master 0 preferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            prio_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            prio_q  <= prio_d;
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_wb_flow_arbiter.sv
// Bench for wb_flow_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_wb_flow_arbiter;
    localparam int DW = 8;
    localparam int AW = 1;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] m0_adr = '0, m1_adr = '0, s_adr_o;
    logic [DW-1:0] m0_dat = '0, m1_dat = '0, m0_dat_o, m1_dat_o, s_dat_o, s_dat = '0;
    logic          m0_we = 0, m0_stb = 0, m0_cyc = 0, m0_ack_o, m0_err_o;
    logic          m1_we = 0, m1_stb = 0, m1_cyc = 0, m1_ack_o, m1_err_o;
    logic          s_we_o, s_stb_o, s_cyc_o, s_ack = 0;
    logic [1:0]    gnt;

    int vectors = 0;
    int miscompares = 0;

    wb_flow_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we),
        .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_we_o(s_we_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack), .gnt(gnt)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the bus, who is preferred next, how long
    // the owner has been stalled, and who is locked out.
    int owner = -1;
    bit pref  = 0;
    int stall = 0;
    bit blk0 = 0, blk1 = 0;

    function automatic bit own_stb();
        return (owner == 0) ? m0_stb : (owner == 1) ? m1_stb : 1'b0;
    endfunction
    function automatic bit own_cyc();
        return (owner == 0) ? m0_cyc : (owner == 1) ? m1_cyc : 1'b0;
    endfunction
    function automatic bit aborting();
        return owner >= 0 && own_stb() && !s_ack && stall == TO;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            owner = -1; pref = 0; stall = 0; blk0 = 0; blk1 = 0;
        end else begin
            bit ab, e0, e1;
            int nxt;
            ab  = aborting();
            e0  = m0_cyc && !blk0;
            e1  = m1_cyc && !blk1;
            nxt = owner;
            if (owner < 0) begin
                if (e0 && e1) nxt = pref ? 1 : 0;
                else if (e0) nxt = 0;
                else if (e1) nxt = 1;
                stall = 0;
            end else if (ab || !own_cyc()) begin
                pref  = (owner == 0);
                nxt   = -1;
                stall = 0;
            end else begin
                stall = (s_ack || !own_stb()) ? 0 : stall + 1;
            end
            blk0 = m0_cyc && (blk0 || (ab && owner == 0));
            blk1 = m1_cyc && (blk1 || (ab && owner == 1));
            owner = nxt;
        end
    end

    task automatic clear_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
        s_ack = 0; s_dat = '0;
    endtask

    // Returns right after a falling edge with rst just released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 1; m0_dat = 8'h5A; s_ack = 1;
        @(negedge clk); #2;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b exp 00", gnt); end
        vectors++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin miscompares++; $display("FAIL reset_ctl: got %b exp 000", {s_cyc_o, s_stb_o, s_we_o}); end
        vectors++; if ({s_adr_o, s_dat_o} !== '0) begin miscompares++; $display("FAIL reset_bus: got %h exp 0", {s_adr_o, s_dat_o}); end
        vectors++; if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 4'b0000) begin miscompares++; $display("FAIL reset_ackerr: got %b exp 0000", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}); end
        clear_inputs();
    endtask

    task automatic test_single();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 1; m1_dat = 8'hA5;
        #2;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL single_latency: got %b exp 00", gnt); end
        @(negedge clk);
        s_ack = 1; s_dat = 8'h3C;
        #2;
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL single_gnt: got %b exp 10", gnt); end
        vectors++; if ({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o} !== {3'b111, 1'b1, 8'hA5}) begin miscompares++; $display("FAIL single_bus: got %b exp 1111_a5", {s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o}); end
        vectors++; if ({m1_ack_o, m0_ack_o} !== 2'b10) begin miscompares++; $display("FAIL single_ack: got %b exp 10", {m1_ack_o, m0_ack_o}); end
        vectors++; if ({m0_dat_o, m1_dat_o} !== {8'h3C, 8'h3C}) begin miscompares++; $display("FAIL single_rdat: got %h exp 3c3c", {m0_dat_o, m1_dat_o}); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_contention();
        logic [1:0] exp_g [5];
        exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00; exp_g[4] = 2'b01;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #2;
            vectors++; if (gnt !== exp_g[k]) begin miscompares++; $display("FAIL contention_gnt[%0d]: got %b exp %b", k, gnt, exp_g[k]); end
            case (k)
                0: begin m0_cyc = 0; m0_stb = 0; end
                1: begin m0_cyc = 1; m0_stb = 1; end
                2: begin m1_cyc = 0; m1_stb = 0; end
                3: begin m1_cyc = 1; m1_stb = 1; end
                default: ;
            endcase
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin m1_cyc = 1; m1_stb = 1; end
            m0_stb = k[0];
            s_ack  = k[0];
            #2;
            vectors++; if (gnt !== 2'b01 || m1_ack_o !== 1'b0 || m0_ack_o !== k[0]) begin miscompares++; $display("FAIL lock_hold[%0d]: got gnt=%b acks=%b%b exp gnt=01 acks=%b0", k, gnt, m0_ack_o, m1_ack_o, k[0]); end
        end
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        #2;
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL lock_fall: got %b exp 01", gnt); end
        @(negedge clk); #2;
        vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL lock_idle: got %b exp 00", gnt); end
        @(negedge clk); #2;
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL lock_handover: got %b exp 10", gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_timeout();
        int pulses = 0;
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #2;
            if (m0_err_o === 1'b1) pulses++;
            vectors++; if (m0_err_o !== (k == 5) || m0_ack_o !== 1'b0) begin miscompares++; $display("FAIL timeout_err[%0d]: got err=%b ack=%b exp err=%b ack=0", k, m0_err_o, m0_ack_o, k == 5); end
            vectors++; if (gnt !== ((k <= 5) ? 2'b01 : 2'b00)) begin miscompares++; $display("FAIL timeout_gnt[%0d]: got %b exp %b", k, gnt, (k <= 5) ? 2'b01 : 2'b00); end
        end
        vectors++; if (pulses != 1) begin miscompares++; $display("FAIL timeout_pulses: got %0d exp 1", pulses); end
        m1_cyc = 1; m1_stb = 1;
        @(negedge clk); #2;
        vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL timeout_other: got %b exp 10", gnt); end
        m1_cyc = 0; m1_stb = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #2;
            vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL timeout_blocked[%0d]: got %b exp 00", k, gnt); end
        end
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1; s_ack = 1;
        @(negedge clk); #2;
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL timeout_unblock: got %b exp 01", gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_ack_boundary();
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        @(negedge clk);
        s_ack = 1;
        #2;
        vectors++; if ({m0_ack_o, m0_err_o} !== 2'b10) begin miscompares++; $display("FAIL boundary_ackerr: got %b exp 10", {m0_ack_o, m0_err_o}); end
        @(negedge clk);
        s_ack = 0;
        #2;
        vectors++; if (gnt !== 2'b01 || m0_err_o !== 1'b0) begin miscompares++; $display("FAIL boundary_retain: got gnt=%b err=%b exp gnt=01 err=0", gnt, m0_err_o); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_async_reset();
        do_reset();
        m0_cyc = 1; m0_stb = 1;
        @(negedge clk);
        m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        m1_cyc = 1; m1_stb = 1;
        @(negedge clk);
        s_ack = 1;
        #2;
        vectors++; if (gnt !== 2'b10 || s_cyc_o !== 1'b1) begin miscompares++; $display("FAIL areset_pre: got gnt=%b cyc=%b exp gnt=10 cyc=1", gnt, s_cyc_o); end
        rst = 1;
        #1;
        vectors++; if ({gnt, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o} !== 6'b000000) begin miscompares++; $display("FAIL areset_drop: got %b exp 000000", {gnt, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o}); end
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        #1 rst = 0;
        @(negedge clk);
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        @(negedge clk); #2;
        vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL areset_prio: got %b exp 01", gnt); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_random();
        logic [1:0]    eg;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic [4:0]    ec;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            int ack_pct;
            ack_pct = (k < 300) ? 40 : 12;
            if (m0_cyc) m0_cyc = ($urandom_range(0, 99) >= 12); else m0_cyc = ($urandom_range(0, 99) < 35);
            if (m1_cyc) m1_cyc = ($urandom_range(0, 99) >= 12); else m1_cyc = ($urandom_range(0, 99) < 35);
            m0_stb = m0_cyc && ($urandom_range(0, 99) < 80);
            m1_stb = m1_cyc && ($urandom_range(0, 99) < 80);
            m0_we = 1'($urandom); m1_we = 1'($urandom);
            m0_adr = AW'($urandom); m1_adr = AW'($urandom);
            m0_dat = DW'($urandom); m1_dat = DW'($urandom);
            s_dat = DW'($urandom);
            s_ack = ($urandom_range(0, 99) < ack_pct);
            #2;
            eg = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            ea = (owner == 0) ? m0_adr : (owner == 1) ? m1_adr : '0;
            ed = (owner == 0) ? m0_dat : (owner == 1) ? m1_dat : '0;
            ec = {own_cyc(), own_stb(),
                  (owner == 0) ? m0_we : (owner == 1) ? m1_we : 1'b0,
                  owner >= 0 && s_ack, aborting()};
            vectors++;
            if ({gnt, s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o | m1_ack_o, m0_err_o | m1_err_o,
                 m0_ack_o & (owner != 0), m1_ack_o & (owner != 1), m0_err_o & (owner != 0), m1_err_o & (owner != 1),
                 m0_dat_o, m1_dat_o} !==
                {eg, ea, ed, ec, 4'b0000, s_dat, s_dat}) begin
                miscompares++;
                $display("FAIL random[%0d]: got gnt=%b adr=%h dat=%h ctl=%b%b%b ack=%b%b err=%b%b exp gnt=%b adr=%h dat=%h ctl/ack/err=%b owner=%0d",
                         k, gnt, s_adr_o, s_dat_o, s_cyc_o, s_stb_o, s_we_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                         eg, ea, ed, ec, owner);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_timeout();
        test_ack_boundary();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
